// File: rtl/nios2_debug_vjtag_host_if.sv
// Command/response handshake bundle for the Nios II debug vJTAG host.
// master = command issuer, slave = nios2_debug_vjtag_host.
interface nios2_debug_vjtag_host_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );
endinterface

// File: rtl/nios2_debug_vjtag_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave (IR/DR scans).
// Optional scan abort enabled by defining NIOS2_DBG_HOST_ABORT_EN.
module nios2_debug_vjtag_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2_debug_vjtag_host_if.slave bus,
`ifdef NIOS2_DBG_HOST_ABORT_EN
    input  logic                abort,
    output logic                rsp_aborted,
`endif
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);
    localparam int PER = 2 * TCK_DIV;
    localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
    localparam int BW  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(PER - 1);
    localparam logic [PW-1:0] P_RISE = PW'(TCK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, UIR, CDR, SDR, UDR, RSP
    } state_t;

    state_t              state;
    logic [PW-1:0]       pcnt;
    logic [BW-1:0]       bcnt;
    logic [DR_WIDTH-1:0] sr;
`ifdef NIOS2_DBG_HOST_ABORT_EN
    logic                abort_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            pcnt           <= '0;
            bcnt           <= '0;
            sr             <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_ir_out <= '0;
            vji_tck        <= 1'b0;
            vji_tdi        <= 1'b0;
            vji_ir_in      <= '0;
            vji_rti        <= 1'b1;
            vji_uir        <= 1'b0;
            vji_cdr        <= 1'b0;
            vji_sdr        <= 1'b0;
            vji_udr        <= 1'b0;
`ifdef NIOS2_DBG_HOST_ABORT_EN
            abort_q        <= 1'b0;
            rsp_aborted    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        vji_ir_in     <= bus.cmd_ir;
                        sr            <= bus.cmd_data;
                        bus.cmd_ready <= 1'b0;
                        vji_rti       <= 1'b0;
                        vji_uir       <= 1'b1;
                        pcnt          <= '0;
                        state         <= UIR;
`ifdef NIOS2_DBG_HOST_ABORT_EN
                        abort_q       <= 1'b0;
`endif
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
`ifdef NIOS2_DBG_HOST_ABORT_EN
                        rsp_aborted   <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (pcnt == P_LAST) begin
                        pcnt    <= '0;
                        vji_tck <= 1'b0;
`ifdef NIOS2_DBG_HOST_ABORT_EN
                        // abandon the scan before UDR so the target never commits
                        if ((abort_q || abort) && state != UDR) begin
                            vji_uir       <= 1'b0;
                            vji_cdr       <= 1'b0;
                            vji_sdr       <= 1'b0;
                            vji_tdi       <= 1'b0;
                            vji_rti       <= 1'b1;
                            bcnt          <= '0;
                            abort_q       <= 1'b0;
                            rsp_aborted   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= sr;
                            state         <= RSP;
                        end else
`endif
                        begin
                            unique case (state)
                                UIR: begin
                                    vji_uir <= 1'b0;
                                    vji_cdr <= 1'b1;
                                    state   <= CDR;
                                end
                                CDR: begin
                                    vji_cdr <= 1'b0;
                                    vji_sdr <= 1'b1;
                                    vji_tdi <= sr[0];
                                    state   <= SDR;
                                end
                                SDR: begin
                                    if (bcnt == B_LAST) begin
                                        bcnt    <= '0;
                                        vji_sdr <= 1'b0;
                                        vji_udr <= 1'b1;
                                        vji_tdi <= 1'b0;
                                        state   <= UDR;
                                    end else begin
                                        bcnt    <= bcnt + BW'(1);
                                        vji_tdi <= sr[0];
                                    end
                                end
                                UDR: begin
                                    vji_udr       <= 1'b0;
                                    vji_rti       <= 1'b1;
                                    bus.rsp_valid <= 1'b1;
                                    bus.rsp_data  <= sr;
                                    state         <= RSP;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
`ifdef NIOS2_DBG_HOST_ABORT_EN
                        if (abort && state != UDR)
                            abort_q <= 1'b1;
`endif
                        // tdo is sampled on the edge that raises tck
                        if (pcnt == P_RISE) begin
                            vji_tck <= 1'b1;
                            if (state == CDR)
                                bus.rsp_ir_out <= vji_ir_out;
                            if (state == SDR)
                                sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_debug_vjtag_host.sv
// Directed bench for nios2_debug_vjtag_host with a behavioural vJTAG target.
// Abort scenario built when NIOS2_DBG_HOST_ABORT_EN is defined.
module tb_nios2_debug_vjtag_host;
    localparam int DW = 38;
    localparam int IW = 2;
    localparam logic [DW-1:0] PRE = 38'h00_1234_5678;
    localparam logic [DW-1:0] D1  = 38'h15_5555_5555;
    localparam logic [DW-1:0] D2  = 38'h2A_AAAA_AAAA;
    localparam logic [DW-1:0] D3  = 38'h11_2233_4455;
    localparam logic [DW-1:0] D4  = 38'h22_2222_2222;
    localparam logic [50:0] RST_VEC =
        {1'b1, 1'b0, 38'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    nios2_debug_vjtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b0 ();
    nios2_debug_vjtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b1 ();

    logic tck0, tdi0, tdo0, rti0, uir0, cdr0, sdr0, udr0;
    logic [IW-1:0] ir_in0;
    logic [IW-1:0] ir_out0 = 2'b10;
    logic tck1, tdi1, rti1, uir1, cdr1, sdr1, udr1;
    logic tdo1 = 1'b1;
    logic [IW-1:0] ir_in1;
    logic [IW-1:0] ir_out1 = 2'b01;
`ifdef NIOS2_DBG_HOST_ABORT_EN
    logic abort0 = 1'b0;
    logic abort1 = 1'b0;
    logic aborted0, aborted1;
`endif

    nios2_debug_vjtag_host #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0),
`ifdef NIOS2_DBG_HOST_ABORT_EN
        .abort(abort0), .rsp_aborted(aborted0),
`endif
        .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
        .vji_ir_in(ir_in0), .vji_ir_out(ir_out0),
        .vji_rti(rti0), .vji_uir(uir0), .vji_cdr(cdr0),
        .vji_sdr(sdr0), .vji_udr(udr0)
    );

    nios2_debug_vjtag_host #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1),
`ifdef NIOS2_DBG_HOST_ABORT_EN
        .abort(abort1), .rsp_aborted(aborted1),
`endif
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
        .vji_ir_in(ir_in1), .vji_ir_out(ir_out1),
        .vji_rti(rti1), .vji_uir(uir1), .vji_cdr(cdr1),
        .vji_sdr(sdr1), .vji_udr(udr1)
    );

    logic [50:0] outs0, outs1;
    assign outs0 = {b0.cmd_ready, b0.rsp_valid, b0.rsp_data, b0.rsp_ir_out,
                    tck0, tdi0, ir_in0, rti0, uir0, cdr0, sdr0, udr0};
    assign outs1 = {b1.cmd_ready, b1.rsp_valid, b1.rsp_data, b1.rsp_ir_out,
                    tck1, tdi1, ir_in1, rti1, uir1, cdr1, sdr1, udr1};

    // target DR: capture preload in CDR, shift in SDR, commit on UDR
    logic [DW-1:0] tgt_sr = '0;
    logic [DW-1:0] tgt_dr = '0;
    logic [IW-1:0] tgt_ir = '0;
    assign tdo0 = tgt_sr[0];
    always @(posedge tck0) begin
        if (cdr0) tgt_sr <= PRE;
        else if (sdr0) tgt_sr <= {tdi0, tgt_sr[DW-1:1]};
        else if (udr0) begin
            tgt_dr <= tgt_sr;
            tgt_ir <= ir_in0;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs0 !== RST_VEC || outs1 !== RST_VEC) begin
                errors++;
                $display("FAIL reset: got %h / %h required %h",
                         outs0, outs1, RST_VEC);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_scan();
        int lat;
        int bad;
        bad = 0;
        @(negedge clk);
        b0.cmd_ir = 2'b01;
        b0.cmd_data = D1;
        b0.cmd_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        b0.cmd_valid = 1'b0;
        checks++;
        if (b0.cmd_ready !== 1'b0 || uir0 !== 1'b1) begin
            errors++;
            $display("FAIL accept: cmd_ready=%b uir=%b required 0 1",
                     b0.cmd_ready, uir0);
        end
        while (b0.rsp_valid !== 1'b1 && lat < 400) begin
            if ($countones({rti0, uir0, cdr0, sdr0, udr0}) != 1) bad++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 165) begin
            errors++;
            $display("FAIL latency: got %0d required 165", lat);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL onehot: %0d bad cycles required 0", bad);
        end
        checks++;
        if (b0.rsp_data !== PRE || b0.rsp_ir_out !== 2'b10) begin
            errors++;
            $display("FAIL rsp: data=%h ir=%b required %h 10",
                     b0.rsp_data, b0.rsp_ir_out, PRE);
        end
        checks++;
        if (tgt_dr !== D1 || tgt_ir !== 2'b01) begin
            errors++;
            $display("FAIL target: dr=%h ir=%b required %h 01",
                     tgt_dr, tgt_ir, D1);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        bad = 0;
        b0.cmd_ir = 2'b11;
        b0.cmd_data = D2;
        b0.cmd_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (b0.rsp_valid !== 1'b1 || b0.rsp_data !== PRE ||
                b0.cmd_ready !== 1'b0 || tck0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d unstable cycles required 0", bad);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        checks++;
        if (b0.rsp_valid !== 1'b0 || b0.cmd_ready !== 1'b1 ||
            ir_in0 !== 2'b01) begin
            errors++;
            $display("FAIL handshake: valid=%b ready=%b ir_in=%b required 0 1 01",
                     b0.rsp_valid, b0.cmd_ready, ir_in0);
        end
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        lat = 1;
        checks++;
        if (b0.cmd_ready !== 1'b0 || uir0 !== 1'b1 || ir_in0 !== 2'b11) begin
            errors++;
            $display("FAIL second accept: ready=%b uir=%b ir_in=%b required 0 1 11",
                     b0.cmd_ready, uir0, ir_in0);
        end
        while (b0.rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 165 || b0.rsp_data !== PRE || tgt_dr !== D2 ||
            tgt_ir !== 2'b11) begin
            errors++;
            $display("FAIL second scan: lat=%0d data=%h tgt=%h ir=%b required 165 %h %h 11",
                     lat, b0.rsp_data, tgt_dr, tgt_ir, PRE, D2);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
    endtask

    task automatic test_tck_div1();
        int lat;
        int rises;
        int bad;
        logic prev;
        rises = 0;
        bad = 0;
        b1.cmd_ir = 2'b10;
        b1.cmd_data = 38'h3F_0F0F_0F0F;
        b1.cmd_valid = 1'b1;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        lat = 1;
        prev = 1'b0;
        while (lat < 400) begin
            if (b1.rsp_valid === 1'b1) break;
            if (tck1 && !prev) rises++;
            if (lat >= 2 && tck1 === prev) bad++;
            prev = tck1;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 83) begin
            errors++;
            $display("FAIL div1 latency: got %0d required 83", lat);
        end
        checks++;
        if (rises != 41) begin
            errors++;
            $display("FAIL div1 rises: got %0d required 41", rises);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div1 toggle: %0d stuck cycles required 0", bad);
        end
        checks++;
        if (b1.rsp_data !== 38'h3F_FFFF_FFFF || b1.rsp_ir_out !== 2'b01) begin
            errors++;
            $display("FAIL div1 rsp: data=%h ir=%b required 3fffffffff 01",
                     b1.rsp_data, b1.rsp_ir_out);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
    endtask

    task automatic test_midscan_reset();
        int n;
        int seen;
        int lat;
        n = 0;
        seen = 0;
        b0.cmd_ir = 2'b11;
        b0.cmd_data = 38'h0A_BCDE_F012;
        b0.cmd_valid = 1'b1;
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        while (sdr0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL sdr start: timeout after %0d cycles required <100", n);
        end
        repeat (81) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (outs0 !== RST_VEC) begin
            errors++;
            $display("FAIL abort reset: got %h required %h", outs0, RST_VEC);
        end
        repeat (200) begin
            @(negedge clk);
            if (b0.rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || tgt_dr !== D2) begin
            errors++;
            $display("FAIL no rsp: %0d rsp cycles tgt=%h required 0 %h",
                     seen, tgt_dr, D2);
        end
        b0.cmd_ir = 2'b01;
        b0.cmd_data = D3;
        b0.cmd_valid = 1'b1;
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        lat = 1;
        while (b0.rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 165 || b0.rsp_data !== PRE || tgt_dr !== D3) begin
            errors++;
            $display("FAIL post reset scan: lat=%0d data=%h tgt=%h required 165 %h %h",
                     lat, b0.rsp_data, tgt_dr, PRE, D3);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
    endtask

`ifdef NIOS2_DBG_HOST_ABORT_EN
    task automatic test_abort();
        int n;
        int udr_seen;
        logic [DW-1:0] pre_v;
        logic [DW-1:0] d_v;
        logic [DW-1:0] exp_v;
        n = 0;
        udr_seen = 0;
        pre_v = PRE;
        d_v = D4;
        exp_v = {pre_v[10:0], d_v[37:11]};
        b0.cmd_ir = 2'b10;
        b0.cmd_data = D4;
        b0.cmd_valid = 1'b1;
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        while (sdr0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (41) @(negedge clk);
        abort0 = 1'b1;
        n = 0;
        while (b0.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            abort0 = 1'b0;
            if (udr0 === 1'b1) udr_seen++;
            n++;
        end
        checks++;
        if (n != 3 || aborted0 !== 1'b1) begin
            errors++;
            $display("FAIL abort rsp: delay=%0d aborted=%b required 3 1",
                     n, aborted0);
        end
        checks++;
        if (udr_seen != 0 || tgt_dr !== D3) begin
            errors++;
            $display("FAIL abort udr: udr=%0d tgt=%h required 0 %h",
                     udr_seen, tgt_dr, D3);
        end
        checks++;
        if (b0.rsp_data !== exp_v) begin
            errors++;
            $display("FAIL abort data: got %h required %h", b0.rsp_data, exp_v);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        checks++;
        if (aborted0 !== 1'b0 || b0.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort clear: aborted=%b ready=%b required 0 1",
                     aborted0, b0.cmd_ready);
        end
    endtask
`endif

    initial begin
        b0.cmd_valid = 1'b0;
        b0.cmd_ir = '0;
        b0.cmd_data = '0;
        b0.rsp_ready = 1'b0;
        b1.cmd_valid = 1'b0;
        b1.cmd_ir = '0;
        b1.cmd_data = '0;
        b1.rsp_ready = 1'b0;
        test_reset();
        test_single_scan();
        test_back_to_back();
        test_tck_div1();
        test_midscan_reset();
`ifdef NIOS2_DBG_HOST_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
